// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// One request in flight; rvalid pulses LATENCY edges after acceptance.
module data_mem_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   lwr;
  logic                   lrd;
  logic [ADDR_BITS+1:0]   laddr;
  logic [31:0]            lwdata;
  logic [31:0]            mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]   idx;
  logic                   aligned;
  logic                   fire;
  logic                   unused_addr;

  // Upper address bits alias onto the array and never flag an error.
  assign unused_addr = ^addr[31:ADDR_BITS+2];

  assign idx     = laddr[ADDR_BITS+1:2];
  assign aligned = (laddr[1:0] == 2'b00);
  assign fire    = (state == WAIT) && (cnt == 4'd0);
  assign ready   = (state == IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && (we || re)) begin
            lwr    <= we;
            lrd    <= re && !we;
            laddr  <= addr[ADDR_BITS+1:0];
            lwdata <= wdata;
            cnt    <= CNT_INIT;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= RESP;
            rvalid <= 1'b1;
            err    <= !aligned;
            rdata  <= (lrd && aligned) ? mem[idx] : 32'h0;
          end
        end
        RESP: begin
          state  <= IDLE;
          rvalid <= 1'b0;
          err    <= 1'b0;
          rdata  <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so a reset on the RESP-entry edge aborts the store.
  always_ff @(posedge clk) begin
    if (rst && fire && lwr && aligned) begin
      mem[idx] <= lwdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 1 and 15.
// Vector table plus hand sequences for reset and in-flight corner cases.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [3];
  logic        we    [3];
  logic        re    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];

  int lats[3] = '{2, 1, 15};
  int vecs = 0;
  int bad  = 0;

  data_mem_responder #(.LATENCY(2), .ADDR_BITS(8)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .re(re[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
    .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );
  data_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .re(re[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
    .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );
  data_mem_responder #(.LATENCY(15), .ADDR_BITS(8)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .re(re[2]),
    .addr(addr[2]), .wdata(wdata[2]), .ready(ready[2]),
    .rvalid(rvalid[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2])
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tv[11];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(int k, logic w, logic r, logic [31:0] a,
                      logic [31:0] d, logic [31:0] ed, logic ee,
                      string name);
    int n;
    n = 0;
    while (!ready[k] && n < 40) begin
      tick();
      n++;
    end
    chk({name, " ready_in"}, 32'(ready[k]), 32'd1);
    req[k] = 1'b1; we[k] = w; re[k] = r; addr[k] = a; wdata[k] = d;
    tick();
    req[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
    chk({name, " busy"}, 32'(busy[k]), 32'd1);
    n = 0;
    while (!rvalid[k] && n < 40) begin
      tick();
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lats[k]));
    chk({name, " rdata"}, rdata[k], ed);
    chk({name, " err"}, 32'(err[k]), 32'(ee));
    chk({name, " ready_resp"}, 32'(ready[k]), 32'd0);
    tick();
    chk({name, " rvalid_end"}, 32'(rvalid[k]), 32'd0);
    chk({name, " ready_end"}, 32'(ready[k]), 32'd1);
    chk({name, " rdata_end"}, rdata[k], 32'h0);
    chk({name, " err_end"}, 32'(err[k]), 32'd0);
  endtask

  task automatic spacing(int k);
    int n;
    req[k] = 1'b1; we[k] = 1'b1; re[k] = 1'b0;
    addr[k] = 32'h80; wdata[k] = 32'(k);
    n = 0;
    while (!rvalid[k] && n < 60) begin
      tick();
      n++;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!rvalid[k] && n < 60);
    chk($sformatf("spacing%0d", k), 32'(n), 32'(lats[k] + 2));
    req[k] = 1'b0; we[k] = 1'b0;
    tick();
    tick();
    chk($sformatf("spacing%0d idle", k), 32'(ready[k]), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;

    tv[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    tv[1]  = '{1'b0, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h13,       32'hFFFFFFFF, 32'h0,        1'b1};
    tv[3]  = '{1'b0, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 32'h400,      32'h12345678, 32'h0,        1'b0};
    tv[5]  = '{1'b0, 1'b1, 32'h000,      32'h0,        32'h12345678, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 32'h24,       32'hCAFEF00D, 32'h0,        1'b0};
    tv[7]  = '{1'b0, 1'b1, 32'h24,       32'h0,        32'hCAFEF00D, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 32'h21,       32'h0,        32'h0,        1'b1};
    tv[9]  = '{1'b0, 1'b1, 32'hFFFFFC10, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h20,       32'h11111111, 32'h0,        1'b0};

    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d ready", k), 32'(ready[k]), 32'd1);
      chk($sformatf("rst%0d busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst%0d rvalid", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("rst%0d rdata", k), rdata[k], 32'h0);
      chk($sformatf("rst%0d err", k), 32'(err[k]), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      xact(0, tv[i].w, tv[i].r, tv[i].a, tv[i].d, tv[i].ed, tv[i].ee,
           $sformatf("vec%0d", i));
    end

    // req without we/re must be ignored
    req[0] = 1'b1; addr[0] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noop ready", 32'(ready[0]), 32'd1);
      chk("noop rvalid", 32'(rvalid[0]), 32'd0);
    end
    req[0] = 1'b0;

    // reset one cycle after acceptance aborts the write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hAAAA5555;
    tick();
    req[0] = 1'b0; we[0] = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort ready", 32'(ready[0]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rvalid[0]) seen = 1'b1;
      tick();
    end
    chk("abort no rvalid", 32'(seen), 32'd0);
    xact(0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h11111111, 1'b0, "abort read");

    // inputs changing during WAIT do not disturb the in-flight write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h5A5A5A5A;
    tick();
    we[0] = 1'b0; re[0] = 1'b1; addr[0] = 32'h13; wdata[0] = 32'h0;
    tick();
    addr[0] = 32'h44; we[0] = 1'b1; wdata[0] = 32'h99999999;
    tick();
    req[0] = 1'b0; we[0] = 1'b0; re[0] = 1'b0;
    chk("toggle rvalid", 32'(rvalid[0]), 32'd1);
    chk("toggle rdata", rdata[0], 32'h0);
    chk("toggle err", 32'(err[0]), 32'd0);
    tick();
    xact(0, 1'b0, 1'b1, 32'h30, 32'h0, 32'h5A5A5A5A, 1'b0, "toggle read");

    // reset during RESP keeps the completed write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h50; wdata[0] = 32'h77;
    tick();
    req[0] = 1'b0; we[0] = 1'b0;
    n = 0;
    while (!rvalid[0] && n < 40) begin
      tick();
      n++;
    end
    chk("resp rst rvalid_before", 32'(rvalid[0]), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("resp rst rvalid", 32'(rvalid[0]), 32'd0);
    chk("resp rst ready", 32'(ready[0]), 32'd1);
    xact(0, 1'b0, 1'b1, 32'h50, 32'h0, 32'h77, 1'b0, "resp rst read");

    for (int k = 1; k < 3; k++) begin
      xact(k, 1'b1, 1'b0, 32'h10, 32'hBEEF0000 + 32'(k), 32'h0, 1'b0,
           $sformatf("lat%0d wr", lats[k]));
      xact(k, 1'b0, 1'b1, 32'h10, 32'h0, 32'hBEEF0000 + 32'(k), 1'b0,
           $sformatf("lat%0d rd", lats[k]));
    end
    for (int k = 0; k < 3; k++) spacing(k);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: edges from request acceptance to response; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 8: log2 of word depth; the array is 2^ADDR_BITS x 32 bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 req  input  1  request strobe from the pipeline memory stage.
REQ-006 we  input  1  write request (MemWrite).
REQ-007 re  input  1  read request (MemRead).
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data (ReadData2).
REQ-010 ready  output  1  responder can accept a request this cycle; the pipeline stalls while it is low.
REQ-011 rvalid  output  1  one-cycle response pulse.
REQ-012 rdata  output  32  load data; valid only while rvalid is high.
REQ-013 err  output  1  misaligned-access flag; valid only while rvalid is high.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP, plus a 4-bit wait counter cnt.
REQ-016 ready SHALL be 1 only in IDLE; busy SHALL equal !ready.
REQ-017 A request SHALL be accepted at edge E when it is sampled in IDLE with req=1 and (we|re)=1.
  - At acceptance: latch we, re, addr and wdata; load cnt=LATENCY-1; go to WAIT.
REQ-018 A sample with req=1 and we=re=0 SHALL be ignored: state stays IDLE, no response.
REQ-019 If we=1 and re=1 together, the request SHALL be treated as a write only.
REQ-020 WAIT behaviour SHALL be:
  - cnt!=0: decrement cnt.
  - cnt==0: go to RESP.
  - Result: RESP is entered at edge E+LATENCY.
REQ-021 The following SHALL occur on the edge that enters RESP:
  - Write: mem[addr[ADDR_BITS+1:2]] <= latched wdata.
  - Read: rdata is registered from the array.
  - rvalid and err are registered.
REQ-022 rvalid SHALL be high for exactly the one cycle after edge E+LATENCY; RESP SHALL return to IDLE on the next edge.
  - ready is high again after edge E+LATENCY+1.
  - Maximum throughput is one request per LATENCY+2 cycles.
REQ-023 On a write response, rdata SHALL be 32'h0 and rvalid SHALL still pulse (as an acknowledge).
REQ-024 addr[1:0]!=0 SHALL produce a response with err=1 and rdata=0; the array SHALL NOT be modified.
REQ-025 Address bits above ADDR_BITS+1 SHALL be ignored (aliasing/wrap-around); they SHALL NOT be an error.
REQ-026 Request inputs SHALL be ignored outside IDLE; an in-flight request SHALL NOT be affected by input changes.
REQ-027 rdata and err SHALL hold 0 whenever rvalid is 0.
REQ-028 A read following a write to the same word SHALL return the new data.

Reset
REQ-029 The following SHALL apply when rst=0 at a rising edge:
  - State goes to IDLE and cnt=0.
  - rvalid=0, err=0, rdata=0.
  - ready=1 and busy=0 from the following cycle.
REQ-030 Reset during WAIT SHALL abort the request: no array write and no response.
REQ-031 Reset during RESP SHALL clear rvalid; an array write already performed SHALL remain.
REQ-032 Array contents SHALL NOT be cleared by reset.

Verification
REQ-033 The bench SHALL cover these scenarios (LATENCY=2 unless stated):
  - Write then read: write 0xDEADBEEF to 0x10 at edge E -> rvalid after E+2 with rdata=0 and err=0; ready after E+3. Read of 0x10 -> rdata=0xDEADBEEF.
  - Misaligned access: write to 0x13 -> err=1 and rdata=0; a subsequent read of 0x10 still returns 0xDEADBEEF.
  - Aliasing: write 0x12345678 to 0x400 (ADDR_BITS=8) -> a read of 0x000 returns 0x12345678.
  - Reset abort: write 0xAAAA5555 to 0x20, assert rst=0 one cycle later -> no rvalid, ready=1 after reset; a later read of 0x20 returns the prior contents.
  - Input handling: req with we=re=0 -> no response, ready stays 1. we=re=1 -> write performed. Inputs toggled during WAIT -> response unchanged.
  - Latency sweep: LATENCY=1 and LATENCY=15 -> rvalid exactly LATENCY edges after acceptance, with back-to-back request spacing of LATENCY+2 cycles.
